// File: rtl/fp_div_sqrt_scheduler_pkg.sv
// Shared FPU types for the divide/sqrt scheduler.
//   FDivSqrtReqPath    : operands and tag captured from the granted thread
//   FDivSqrtSchedState : scheduler FSM states
//   fdiv_sqrt_eff_rhs  : rhs as seen by the unit (forced to 0 for sqrt)
package fp_div_sqrt_scheduler_pkg;

  // Widest tag the scheduler can carry; the top keeps only TAG_WIDTH bits of it.
  localparam int FDIV_MAX_TAG_WIDTH = 16;

  typedef struct packed {
    logic                          is_divide;
    logic [31:0]                   lhs;
    logic [31:0]                   rhs;
    logic [2:0]                    round_mode;
    logic [FDIV_MAX_TAG_WIDTH-1:0] tag;
  } FDivSqrtReqPath;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } FDivSqrtSchedState;

  function automatic logic [31:0] fdiv_sqrt_eff_rhs(input logic is_divide,
                                                    input logic [31:0] rhs);
    return is_divide ? rhs : 32'h0;
  endfunction

endpackage

// File: rtl/fp_div_sqrt_rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index of the highest-priority requester this cycle
//   grant : one-hot grant (all zero when nothing is requested)
// The pointer register lives in the parent.
module fp_div_sqrt_rr_picker
  import fp_div_sqrt_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  int   idx;
  logic found;

  // Scan from ptr upward with wrap-around; the first active request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_div_sqrt_scheduler.sv
// Shares one iterative FP divide/sqrt unit between the SMT threads.
//   clk, rst                    : clock, async active-high reset
//   req_*                       : per-thread request (valid/ready, op, operands, rm, tag)
//   flush                       : per-thread kill
//   unit_start / unit_*         : start pulse and operands to the unit (held until done)
//   unit_done / result / fflags : completion from the unit
//   resp_*                      : response to the owning thread (valid/ready)
module fp_div_sqrt_scheduler
  import fp_div_sqrt_scheduler_pkg::*;
#(
  parameter int NUM_THREADS = 2,
  parameter int TAG_WIDTH   = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_THREADS-1:0]           req_valid,
  output logic [NUM_THREADS-1:0]           req_ready,
  input  logic [NUM_THREADS-1:0]           req_is_divide,
  input  logic [NUM_THREADS*32-1:0]        req_lhs,
  input  logic [NUM_THREADS*32-1:0]        req_rhs,
  input  logic [NUM_THREADS*3-1:0]         req_rm,
  input  logic [NUM_THREADS*TAG_WIDTH-1:0] req_tag,
  input  logic [NUM_THREADS-1:0]           flush,
  output logic                             unit_start,
  output logic                             unit_is_divide,
  output logic [31:0]                      unit_lhs,
  output logic [31:0]                      unit_rhs,
  output logic [2:0]                       unit_rm,
  input  logic                             unit_done,
  input  logic [31:0]                      unit_result,
  input  logic [4:0]                       unit_fflags,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [$clog2(NUM_THREADS)-1:0]   resp_thread,
  output logic [TAG_WIDTH-1:0]             resp_tag,
  output logic [31:0]                      resp_data,
  output logic [4:0]                       resp_fflags
);

  localparam int PTR_W = $clog2(NUM_THREADS);

  FDivSqrtSchedState    state;
  FDivSqrtReqPath       op_q;
  FDivSqrtReqPath       sel_req;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     owner;
  logic [PTR_W-1:0]     sel_thread;
  logic [NUM_THREADS-1:0] grant;
  logic                 killed;
  logic [31:0]          res_data;
  logic [4:0]           res_fflags;
  logic                 accept;
  logic                 owner_flush;
  logic                 unused_tag_bits;

  fp_div_sqrt_rr_picker #(.NUM_REQ(NUM_THREADS)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Mux the granted thread's request fields; sqrt requests get rhs cleared here
  // so the unit never sees a stale divisor.
  always_comb begin
    sel_thread = '0;
    sel_req    = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (grant[i]) begin
        sel_thread         = PTR_W'(i);
        sel_req.is_divide  = req_is_divide[i];
        sel_req.lhs        = req_lhs[i*32 +: 32];
        sel_req.rhs        = fdiv_sqrt_eff_rhs(req_is_divide[i], req_rhs[i*32 +: 32]);
        sel_req.round_mode = req_rm[i*3 +: 3];
        sel_req.tag        = FDIV_MAX_TAG_WIDTH'(req_tag[i*TAG_WIDTH +: TAG_WIDTH]);
      end
    end
  end

  // A thread flushing in the same cycle loses its grant slot for that cycle.
  // Gated by rst so nothing is offered while reset is held.
  assign req_ready   = (state == IDLE && !rst) ? (grant & ~flush) : '0;
  assign accept      = |req_ready;
  assign owner_flush = flush[owner];

  // Scheduler FSM. A killed op still waits for the unit's done so the unit is
  // never restarted while busy; that done is then dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      rr_ptr     <= '0;
      owner      <= '0;
      killed     <= 1'b0;
      res_data   <= '0;
      res_fflags <= '0;
      unit_start <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= sel_req;
            owner      <= sel_thread;
            rr_ptr     <= (sel_thread == PTR_W'(NUM_THREADS - 1)) ? '0 : sel_thread + 1'b1;
            killed     <= 1'b0;
            unit_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          unit_start <= 1'b0;
          if (owner_flush) killed <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (unit_done) begin
            killed <= 1'b0;
            if (killed || owner_flush) begin
              state <= IDLE;
            end else begin
              res_data   <= unit_result;
              res_fflags <= unit_fflags;
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end else if (owner_flush) begin
            killed <= 1'b1;
          end
        end
        RESP: begin
          if (owner_flush || resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign unit_is_divide  = op_q.is_divide;
  assign unit_lhs        = op_q.lhs;
  assign unit_rhs        = op_q.rhs;
  assign unit_rm         = op_q.round_mode;
  assign resp_thread     = owner;
  assign resp_tag        = op_q.tag[TAG_WIDTH-1:0];
  assign resp_data       = res_data;
  assign resp_fflags     = res_fflags;
  assign unused_tag_bits = ^op_q.tag;

endmodule

// File: tb/tb_fp_div_sqrt_scheduler.sv
module tb_fp_div_sqrt_scheduler;

  localparam int N  = 2;
  localparam int TW = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_is_divide = '0;
  logic [N*32-1:0] req_lhs = '0;
  logic [N*32-1:0] req_rhs = '0;
  logic [N*3-1:0]  req_rm = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N-1:0]    flush = '0;
  logic            unit_start, unit_is_divide;
  logic [31:0]     unit_lhs, unit_rhs;
  logic [2:0]      unit_rm;
  logic            unit_done;
  logic [31:0]     unit_result;
  logic [4:0]      unit_fflags;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic            resp_thread;
  logic [TW-1:0]   resp_tag;
  logic [31:0]     resp_data;
  logic [4:0]      resp_fflags;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_div_sqrt_scheduler #(.NUM_THREADS(N), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_divide(req_is_divide),
    .req_lhs(req_lhs), .req_rhs(req_rhs), .req_rm(req_rm), .req_tag(req_tag),
    .flush(flush),
    .unit_start(unit_start), .unit_is_divide(unit_is_divide), .unit_lhs(unit_lhs),
    .unit_rhs(unit_rhs), .unit_rm(unit_rm), .unit_done(unit_done),
    .unit_result(unit_result), .unit_fflags(unit_fflags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_thread(resp_thread),
    .resp_tag(resp_tag), .resp_data(resp_data), .resp_fflags(resp_fflags)
  );

  // Reference arithmetic of the stub unit: exact answers for the plan's
  // operands, an arbitrary but deterministic mix otherwise.
  function automatic logic [31:0] res_fn(input logic d, input logic [31:0] a, input logic [31:0] b);
    if (d && a == 32'h3F800000 && b == 32'h40000000) return 32'h3F000000;
    if (!d && a == 32'h40800000) return 32'h40000000;
    return a ^ {b[15:0], b[31:16]} ^ (d ? 32'h1 : 32'h2);
  endfunction

  function automatic logic [4:0] ff_fn(input logic [31:0] a, input logic [31:0] b);
    return a[4:0] ^ b[4:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural divide/sqrt unit with programmable latency.
  int          lat = 12;
  logic        stub_done, stub_busy, extra_done = 1'b0;
  int          stub_cnt;
  logic        s_div;
  logic [31:0] s_lhs, s_rhs;

  assign unit_done   = stub_done | extra_done;
  assign unit_result = res_fn(s_div, s_lhs, s_rhs);
  assign unit_fflags = ff_fn(s_lhs, s_rhs);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_done <= 1'b0; stub_busy <= 1'b0; stub_cnt <= 0;
      s_div <= 1'b0; s_lhs <= '0; s_rhs <= '0;
    end else begin
      stub_done <= 1'b0;
      if (unit_start && !stub_busy) begin
        s_div <= unit_is_divide; s_lhs <= unit_lhs; s_rhs <= unit_rhs;
        if (lat <= 1) stub_done <= 1'b1;
        else begin stub_busy <= 1'b1; stub_cnt <= lat - 1; end
      end else if (stub_busy) begin
        if (stub_cnt == 1) begin stub_done <= 1'b1; stub_busy <= 1'b0; end
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // Transaction model: one op in flight, tracked by its accept cycle, a kill
  // flag and whether its result is waiting for the consumer. Compared on every
  // falling edge, then advanced to reflect the coming rising edge.
  int          cyc = 0;
  bit          m_active, m_res, m_killed;
  int          m_owner, m_accept, m_ptr;
  logic        m_div;
  logic [31:0] m_lhs, m_rhs, m_data;
  logic [2:0]  m_rm;
  logic [TW-1:0] m_tag;
  logic [4:0]  m_ff;

  initial begin : model
    int win, t;
    logic [N-1:0] exp_ready;
    bit kill_now;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 0; m_res = 0; m_killed = 0; m_ptr = 0;
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_unit_start", 32'(unit_start), 32'h0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("rst_unit_lhs", unit_lhs, 32'h0);
        checkOutput("rst_resp_data", resp_data, 32'h0);
        cyc++;
        continue;
      end
      exp_ready = '0;
      win = -1;
      if (!m_active)
        for (int k = 0; k < N; k++) begin
          t = (m_ptr + k) % N;
          if (win < 0 && req_valid[t]) win = t;
        end
      if (win >= 0 && !flush[win]) exp_ready[win] = 1'b1;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("unit_start", 32'(unit_start), 32'(m_active && !m_res && cyc == m_accept + 1));
      checkOutput("resp_valid", 32'(resp_valid), 32'(m_res));
      if (m_active && !m_res) begin
        checkOutput("unit_is_divide", 32'(unit_is_divide), 32'(m_div));
        checkOutput("unit_lhs", unit_lhs, m_lhs);
        checkOutput("unit_rhs", unit_rhs, m_rhs);
        checkOutput("unit_rm", 32'(unit_rm), 32'(m_rm));
      end
      if (m_res) begin
        checkOutput("resp_thread", 32'(resp_thread), 32'(m_owner));
        checkOutput("resp_tag", 32'(resp_tag), 32'(m_tag));
        checkOutput("resp_data", resp_data, m_data);
        checkOutput("resp_fflags", 32'(resp_fflags), 32'(m_ff));
      end
      if (!m_active) begin
        if (exp_ready != '0) begin
          m_active = 1; m_res = 0; m_killed = 0;
          m_owner = win; m_accept = cyc; m_ptr = (win + 1) % N;
          m_div = req_is_divide[win];
          m_lhs = req_lhs[win*32 +: 32];
          m_rhs = m_div ? req_rhs[win*32 +: 32] : 32'h0;
          m_rm  = req_rm[win*3 +: 3];
          m_tag = req_tag[win*TW +: TW];
        end
      end else if (!m_res) begin
        kill_now = m_killed || flush[m_owner];
        m_killed = kill_now;
        if (cyc > m_accept + 1 && unit_done) begin
          if (kill_now) begin m_active = 0; m_killed = 0; end
          else begin
            m_res = 1;
            m_data = res_fn(m_div, m_lhs, m_rhs);
            m_ff = ff_fn(m_lhs, m_rhs);
          end
        end
      end else if (flush[m_owner] || resp_ready) begin
        m_active = 0; m_res = 0;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one request from thread t and hold it until accepted.
  task automatic applyStimulus(input int t, input logic d, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] rm, input logic [TW-1:0] tag);
    bit got;
    tick();
    req_is_divide[t]      = d;
    req_lhs[t*32 +: 32]   = a;
    req_rhs[t*32 +: 32]   = b;
    req_rm[t*3 +: 3]      = rm;
    req_tag[t*TW +: TW]   = tag;
    req_valid[t]          = 1'b1;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (req_ready[t]) got = 1;
    end
    if (!got) checkOutput("accept_timeout", 32'(req_ready[t]), 32'h1);
    tick();
    req_valid[t] = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    if (!resp_valid) checkOutput("resp_timeout", 32'(resp_valid), 32'h1);
  endtask

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;
    int grants[$];
    int rem0, rem1;
    bit seen;

    resp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single divide 1.0 / 2.0 from T0.
    applyStimulus(0, 1'b1, 32'h3F800000, 32'h40000000, 3'd0, 6'd5);
    wait_resp(n);
    checkOutput("div_latency", 32'(n), 32'd14);
    checkOutput("div_data", resp_data, 32'h3F000000);
    checkOutput("div_thread", 32'(resp_thread), 32'h0);
    checkOutput("div_tag", 32'(resp_tag), 32'd5);
    checkOutput("div_fflags", 32'(resp_fflags), 32'h0);
    tick();

    // Sqrt 4.0 from T1, with a non-owner flush mid-flight.
    applyStimulus(1, 1'b0, 32'h40800000, 32'hDEADBEEF, 3'd2, 6'd9);
    @(negedge clk);
    checkOutput("sqrt_unit_rhs", unit_rhs, 32'h0);
    checkOutput("sqrt_unit_is_divide", 32'(unit_is_divide), 32'h0);
    tick(); tick();
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    wait_resp(n);
    checkOutput("sqrt_data", resp_data, 32'h40000000);
    checkOutput("sqrt_thread", 32'(resp_thread), 32'h1);
    checkOutput("sqrt_tag", 32'(resp_tag), 32'd9);
    tick();

    // Stray done while idle must not produce a response.
    extra_done = 1'b1;
    tick();
    extra_done = 1'b0;
    repeat (3) tick();

    // Round-robin: both threads request continuously for four ops each.
    lat = 3;
    rem0 = 4; rem1 = 4;
    for (int c = 0; c < 300 && (rem0 > 0 || rem1 > 0); c++) begin
      tick();
      req_valid[0] = (rem0 > 0);
      req_valid[1] = (rem1 > 0);
      req_is_divide = 2'b11;
      req_lhs = {32'h40400000 + 32'(rem1), 32'h41000000 + 32'(rem0)};
      req_rhs = {32'h3F800003, 32'h40A00001};
      req_rm  = {3'd1, 3'd4};
      req_tag = {6'(rem1 + 16), 6'(rem0)};
      @(negedge clk);
      if (req_valid[0] && req_ready[0]) begin grants.push_back(0); rem0--; end
      if (req_valid[1] && req_ready[1]) begin grants.push_back(1); rem1--; end
    end
    tick();
    req_valid = '0;
    repeat (12) tick();
    checkOutput("rr_count", 32'(grants.size()), 32'd8);
    for (int i = 0; i < grants.size() && i < 8; i++)
      checkOutput($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));

    // Flush of the owner in WAIT; T1 waits behind it.
    lat = 12;
    applyStimulus(0, 1'b1, 32'h40400000, 32'h3F800000, 3'd0, 6'd3);
    req_is_divide[1]  = 1'b1;
    req_lhs[63:32]    = 32'h3F800000;
    req_rhs[63:32]    = 32'h40000000;
    req_tag[11:6]     = 6'd12;
    req_valid[1]      = 1'b1;
    repeat (4) tick();
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (unit_done) seen = 1;
    end
    if (!seen) checkOutput("flush_done_timeout", 32'(unit_done), 32'h1);
    @(negedge clk);
    checkOutput("flush_wait_ready", 32'(req_ready), 32'h2);
    checkOutput("flush_wait_no_resp", 32'(resp_valid), 32'h0);
    tick();
    req_valid[1] = 1'b0;
    wait_resp(n);
    checkOutput("post_flush_data", resp_data, 32'h3F000000);
    checkOutput("post_flush_thread", 32'(resp_thread), 32'h1);
    tick();

    // Back-pressure then owner flush while the response is pending.
    resp_ready = 1'b0;
    applyStimulus(0, 1'b1, 32'h3F800000, 32'h40000000, 3'd0, 6'd7);
    wait_resp(n);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      checkOutput("bp_valid", 32'(resp_valid), 32'h1);
      checkOutput("bp_data", resp_data, 32'h3F000000);
      checkOutput("bp_tag", 32'(resp_tag), 32'd7);
    end
    tick();
    flush[0] = 1'b1;
    req_is_divide[1] = 1'b0;
    req_lhs[63:32]   = 32'h40800000;
    req_valid[1]     = 1'b1;
    @(negedge clk);
    checkOutput("resp_flush_same_cycle", 32'(resp_valid), 32'h1);
    tick();
    flush[0] = 1'b0;
    @(negedge clk);
    checkOutput("resp_flush_dropped", 32'(resp_valid), 32'h0);
    checkOutput("resp_flush_idle", 32'(req_ready), 32'h2);
    tick();
    req_valid[1] = 1'b0;
    resp_ready = 1'b1;
    wait_resp(n);
    checkOutput("after_resp_flush_data", resp_data, 32'h40000000);
    tick();

    // Asynchronous reset while waiting on the unit.
    applyStimulus(0, 1'b1, 32'h40400000, 32'h3F800000, 3'd3, 6'd1);
    repeat (4) tick();
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    checkOutput("arst_unit_start", 32'(unit_start), 32'h0);
    checkOutput("arst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("arst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("arst_unit_lhs", unit_lhs, 32'h0);
    checkOutput("arst_resp_data", resp_data, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    req_valid = '0;
    tick();
    applyStimulus(1, 1'b0, 32'h40800000, 32'h12345678, 3'd0, 6'd33);
    wait_resp(n);
    checkOutput("arst_fresh_latency", 32'(n), 32'd14);
    checkOutput("arst_fresh_data", resp_data, 32'h40000000);
    checkOutput("arst_fresh_thread", 32'(resp_thread), 32'h1);
    checkOutput("arst_fresh_tag", 32'(resp_tag), 32'd33);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
